// File: rtl/roce_tx_transfer_scheduler_pkg.sv
// Shared types and helpers for the RoCE TX transfer scheduler.
package roce_tx_transfer_scheduler_pkg;

    localparam int unsigned PSN_W = 24;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StDone
    } state_e;

    // Packets needed for a transfer: ceil(length / 2**pmtu_log2), 33-bit so the add cannot overflow.
    function automatic logic [32:0] calc_npkts(input logic [31:0] length,
                                               input int unsigned pmtu_log2);
        logic [32:0] sum;
        sum = {1'b0, length} + ((33'd1 << pmtu_log2) - 33'd1);
        return sum >> pmtu_log2;
    endfunction

endpackage

// File: rtl/roce_tx_transfer_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search from ptr, pointer advances past each grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    // (base + off) mod NUM_REQ, with both operands already below NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    logic found;

    // First requester at or after ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[wrap_add(ptr, i)]) begin
                found                    = 1'b1;
                grant[wrap_add(ptr, i)]  = 1'b1;
                grant_idx                = wrap_add(ptr, i);
            end
        end
    end

    // Pointer moves to the channel after the one just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= wrap_add(grant_idx, 1);
        end
    end

endmodule

// File: rtl/roce_tx_transfer_scheduler.sv
// Schedules RDMA WRITE transfers from several requesters into the RoCE TX stack.
module roce_tx_transfer_scheduler
    import roce_tx_transfer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned PMTU           = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    s_req_valid,
    output logic [NUM_REQ-1:0]    s_req_ready,
    input  logic [NUM_REQ*32-1:0] s_req_length,
    input  logic [NUM_REQ*48-1:0] s_req_addr,
    input  logic [23:0]           cfg_rem_qpn,
    input  logic [31:0]           cfg_r_key,
    input  logic [31:0]           cfg_rem_ip_addr,
    input  logic                  cfg_psn_load,
    input  logic [23:0]           cfg_init_psn,
    output logic [31:0]           m_dma_transfer_length,
    output logic [47:0]           m_rem_addr,
    output logic [23:0]           m_rem_psn,
    output logic [23:0]           m_rem_qpn,
    output logic [31:0]           m_r_key,
    output logic [31:0]           m_rem_ip_addr,
    output logic                  m_start_transfer,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    input  logic                  mon_tlast,
    output logic                  done,
    output logic [ID_W-1:0]       done_id,
    output logic                  done_err,
    output logic                  busy
);

    localparam int unsigned PMTU_LOG2 = $clog2(PMTU);

    state_e             state;
    logic [ID_W-1:0]    cur_id;
    logic [32:0]        npkts;
    logic [32:0]        pkt_cnt;
    logic [31:0]        timer;
    logic               start_cnt;
    logic [PSN_W-1:0]   psn;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    // Pointer lives in the arbiter; kept visible here for debug only.
    logic [ID_W-1:0]    unused_rr_ptr;
    logic               advance;
    logic               beat;
    logic               pkt_done;

    logic [31:0]        req_len  [NUM_REQ];
    logic [47:0]        req_addr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_len[g]  = s_req_length[32*g +: 32];
        assign req_addr[g] = s_req_addr[48*g +: 48];
    end

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (s_req_valid),
        .advance  (advance),
        .ptr      (unused_rr_ptr),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    // Handshake completes combinationally while idle.
    always_comb begin
        advance     = (state == StIdle) && (|s_req_valid);
        s_req_ready = (state == StIdle) ? grant : '0;
        beat        = mon_tvalid & mon_tready & mon_tlast;
        pkt_done    = (pkt_cnt + 33'(beat)) >= npkts;
        busy        = (state != StIdle);
    end

    assign m_rem_psn     = psn;
    assign m_rem_qpn     = cfg_rem_qpn;
    assign m_r_key       = cfg_r_key;
    assign m_rem_ip_addr = cfg_rem_ip_addr;
    assign done_id       = cur_id;

    // Transfer FSM with its counters, PSN tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= StIdle;
            cur_id                <= '0;
            npkts                 <= '0;
            pkt_cnt               <= '0;
            timer                 <= '0;
            start_cnt             <= 1'b0;
            psn                   <= '0;
            m_dma_transfer_length <= '0;
            m_rem_addr            <= '0;
            m_start_transfer      <= 1'b0;
            done                  <= 1'b0;
            done_err              <= 1'b0;
        end else begin
            done     <= 1'b0;
            done_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    // Load lands before the grant so the new transfer sees the new PSN.
                    if (cfg_psn_load) psn <= cfg_init_psn;
                    if (|s_req_valid) begin
                        m_dma_transfer_length <= req_len[grant_idx];
                        m_rem_addr            <= req_addr[grant_idx];
                        cur_id                <= grant_idx;
                        state                 <= StLoad;
                    end
                end
                StLoad: begin
                    npkts     <= calc_npkts(m_dma_transfer_length, PMTU_LOG2);
                    pkt_cnt   <= '0;
                    timer     <= '0;
                    start_cnt <= 1'b0;
                    if (m_dma_transfer_length == 32'd0) begin
                        done     <= 1'b1;
                        done_err <= 1'b1;
                        state    <= StDone;
                    end else begin
                        m_start_transfer <= 1'b1;
                        state            <= StStart;
                    end
                end
                StStart: begin
                    pkt_cnt   <= pkt_cnt + 33'(beat);
                    start_cnt <= 1'b1;
                    if (start_cnt) begin
                        m_start_transfer <= 1'b0;
                        state            <= StWait;
                    end
                end
                StWait: begin
                    pkt_cnt <= pkt_cnt + 33'(beat);
                    // Final beat wins over a simultaneous timeout.
                    if (pkt_done) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                        done     <= 1'b1;
                        done_err <= 1'b1;
                        state    <= StDone;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                StDone: begin
                    // done_err still holds this transfer's status during DONE.
                    if (!done_err) psn <= psn + npkts[PSN_W-1:0];
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_roce_tx_transfer_scheduler.sv
// Directed bench for roce_tx_transfer_scheduler with a completion scoreboard.
module tb_roce_tx_transfer_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned PMTU    = 2048;
    localparam int unsigned TMO     = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    s_req_valid;
    logic [NUM_REQ-1:0]    s_req_ready;
    logic [NUM_REQ*32-1:0] s_req_length;
    logic [NUM_REQ*48-1:0] s_req_addr;
    logic [23:0]           cfg_rem_qpn;
    logic [31:0]           cfg_r_key;
    logic [31:0]           cfg_rem_ip_addr;
    logic                  cfg_psn_load;
    logic [23:0]           cfg_init_psn;
    logic [31:0]           m_dma_transfer_length;
    logic [47:0]           m_rem_addr;
    logic [23:0]           m_rem_psn;
    logic [23:0]           m_rem_qpn;
    logic [31:0]           m_r_key;
    logic [31:0]           m_rem_ip_addr;
    logic                  m_start_transfer;
    logic                  mon_tvalid;
    logic                  mon_tready;
    logic                  mon_tlast;
    logic                  done;
    logic [1:0]            done_id;
    logic                  done_err;
    logic                  busy;

    always #5 clk = ~clk;

    roce_tx_transfer_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .PMTU          (PMTU),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .s_req_valid          (s_req_valid),
        .s_req_ready          (s_req_ready),
        .s_req_length         (s_req_length),
        .s_req_addr           (s_req_addr),
        .cfg_rem_qpn          (cfg_rem_qpn),
        .cfg_r_key            (cfg_r_key),
        .cfg_rem_ip_addr      (cfg_rem_ip_addr),
        .cfg_psn_load         (cfg_psn_load),
        .cfg_init_psn         (cfg_init_psn),
        .m_dma_transfer_length(m_dma_transfer_length),
        .m_rem_addr           (m_rem_addr),
        .m_rem_psn            (m_rem_psn),
        .m_rem_qpn            (m_rem_qpn),
        .m_r_key              (m_r_key),
        .m_rem_ip_addr        (m_rem_ip_addr),
        .m_start_transfer     (m_start_transfer),
        .mon_tvalid           (mon_tvalid),
        .mon_tready           (mon_tready),
        .mon_tlast            (mon_tlast),
        .done                 (done),
        .done_id              (done_id),
        .done_err             (done_err),
        .busy                 (busy)
    );

    typedef struct packed {
        logic [1:0] id;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   start_rises = 0;
    logic start_prev = 1'b0;
    int   sr0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (m_start_transfer && !start_prev) start_rises <= start_rises + 1;
        start_prev <= m_start_transfer;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_id", 64'(done_id), 64'(mon_e.id));
                chk("done_err", 64'(done_err), 64'(mon_e.err));
            end
        end
    end

    // Present a request on one channel in IDLE; returns at the LOAD-cycle negedge.
    task automatic request(input int ch, input logic [31:0] len, input logic [47:0] addr,
                           input logic exp_err, input logic push);
        exp_t e;
        s_req_length[32*ch +: 32] = len;
        s_req_addr[48*ch +: 48]   = addr;
        s_req_valid[ch]           = 1'b1;
        #1;
        chk("req_ready", 64'(s_req_ready), 64'(1) << ch);
        if (push) begin
            e.id  = 2'(ch);
            e.err = exp_err;
            sb.push_back(e);
        end
        @(negedge clk);
        s_req_valid[ch] = 1'b0;
    endtask

    // Wait (bounded) for a grant with other channels possibly valid; expect channel ch.
    task automatic serve_next(input int ch, input logic exp_err);
        logic got;
        exp_t e;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if (s_req_ready != '0) got = 1'b1;
            else @(negedge clk);
        end
        chk("rr_grant", 64'(s_req_ready), 64'(1) << ch);
        e.id  = 2'(ch);
        e.err = exp_err;
        sb.push_back(e);
        @(negedge clk);
        s_req_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic beat(input logic rdy);
        mon_tvalid = 1'b1;
        mon_tready = rdy;
        mon_tlast  = 1'b1;
    endtask

    task automatic no_beat();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        s_req_valid     = '0;
        s_req_length    = '0;
        s_req_addr      = '0;
        cfg_rem_qpn     = 24'hABCDEF;
        cfg_r_key       = 32'h1122_3344;
        cfg_rem_ip_addr = 32'hC0A8_0102;
        cfg_psn_load    = 1'b0;
        cfg_init_psn    = '0;
        no_beat();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(m_start_transfer), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_psn", 64'(m_rem_psn), 64'd0);
        chk("rst_len", 64'(m_dma_transfer_length), 64'd0);
        chk("rst_addr", 64'(m_rem_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("qpn_pass", 64'(m_rem_qpn), 64'hABCDEF);
        chk("rkey_pass", 64'(m_r_key), 64'h1122_3344);

        // PSN load then a 3-packet transfer on ch0; start pulse shape
        cfg_psn_load = 1'b1;
        cfg_init_psn = 24'h000010;
        @(negedge clk);
        cfg_psn_load = 1'b0;
        chk("psn_load", 64'(m_rem_psn), 64'h10);
        request(0, 32'd5000, 48'h1234_5678_9ABC, 1'b0, 1'b1);
        chk("load_start_low", 64'(m_start_transfer), 64'd0);
        chk("load_len", 64'(m_dma_transfer_length), 64'd5000);
        chk("load_addr", 64'(m_rem_addr), 64'h1234_5678_9ABC);
        chk("load_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("start_c1", 64'(m_start_transfer), 64'd1);
        chk("start_psn", 64'(m_rem_psn), 64'h10);
        @(negedge clk);
        chk("start_c2", 64'(m_start_transfer), 64'd1);
        chk("start_addr", 64'(m_rem_addr), 64'h1234_5678_9ABC);
        @(negedge clk);
        chk("start_drop", 64'(m_start_transfer), 64'd0);
        beat(1'b1);
        @(negedge clk);
        beat(1'b1);
        @(negedge clk);
        beat(1'b0);              // tlast without tready must not count
        cfg_psn_load = 1'b1;     // ignored outside IDLE
        cfg_init_psn = 24'h000777;
        @(negedge clk);
        cfg_psn_load = 1'b0;
        chk("done_early", 64'(done), 64'd0);
        beat(1'b1);
        @(negedge clk);
        no_beat();
        chk("done_timely", 64'(done), 64'd1);
        @(negedge clk);
        chk("psn_after", 64'(m_rem_psn), 64'h13);
        chk("idle_busy", 64'(busy), 64'd0);

        // Round-robin with zero-length transfers (rr_ptr is 1 here)
        sr0 = start_rises;
        s_req_valid = 4'b1110;
        serve_next(1, 1'b1);
        serve_next(2, 1'b1);
        serve_next(3, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("zero_no_start", 64'(start_rises), 64'(sr0));
        chk("zero_psn", 64'(m_rem_psn), 64'h13);
        s_req_valid = 4'b1010;
        serve_next(1, 1'b1);
        serve_next(3, 1'b1);
        wait_idle();

        // Timeout: no tlast beats, done_err 64 cycles into WAIT
        request(2, 32'd100, 48'h0000_0000_2000, 1'b1, 1'b1);
        repeat (66) @(negedge clk);
        chk("tmo_early", 64'(done), 64'd0);
        @(negedge clk);
        chk("tmo_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("tmo_psn", 64'(m_rem_psn), 64'h13);
        request(3, 32'd2048, 48'h0000_0000_3000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        beat(1'b1);
        @(negedge clk);
        no_beat();
        chk("after_tmo_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("after_tmo_psn", 64'(m_rem_psn), 64'h14);

        // PSN load together with a request, then wrap across 2^24
        cfg_psn_load = 1'b1;
        cfg_init_psn = 24'hFFFFFE;
        request(0, 32'd4096, 48'hFFFF_0000_0000, 1'b0, 1'b1);
        cfg_psn_load = 1'b0;
        chk("wrap_load_psn", 64'(m_rem_psn), 64'hFFFFFE);
        repeat (3) @(negedge clk);
        beat(1'b1);
        @(negedge clk);
        @(negedge clk);
        no_beat();
        chk("wrap_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("psn_wrap", 64'(m_rem_psn), 64'h000000);

        // Reset during WAIT: back to IDLE, no completion
        request(1, 32'd2048, 48'h0000_0000_4000, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_start", 64'(m_start_transfer), 64'd0);
        chk("rst_mid_psn", 64'(m_rem_psn), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_done", 64'(done), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
